// File: rtl/flag_stack_register_if.sv
// Bus bundle for the flag stack register.
// The master drives ALU flags and stack commands. The slave returns the live
// flag word, the stack view and the sticky error bits.
interface flag_stack_register_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int DEPTH_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   flags;
  logic [WIDTH-1:0]   write_mask;
  logic               push;
  logic               pop;
  logic               err_clear;

  logic [WIDTH-1:0]   status;
  logic [WIDTH-1:0]   saved_top;
  logic [DEPTH_W-1:0] depth;
  logic               empty;
  logic               full;
  logic               overflow_err;
  logic               underflow_err;

  modport master (
    output flags, write_mask, push, pop, err_clear,
    input  status, saved_top, depth, empty, full, overflow_err, underflow_err
  );

  modport slave (
    input  flags, write_mask, push, pop, err_clear,
    output status, saved_top, depth, empty, full, overflow_err, underflow_err
  );
endinterface

// File: rtl/flag_stack_register.sv
// Condition-flag register with a save/restore LIFO for nested exception
// entry and return. The live word takes masked per-bit ALU updates. A push
// saves the live word, a pop restores it, and push+pop swaps it with the top
// entry. Misuse of the stack sets a sticky error bit and never corrupts the
// stack.
module flag_stack_register #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  flag_stack_register_if.slave  bus
);
  localparam int DEPTH_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   status_q, status_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [WIDTH-1:0]   stack_q [DEPTH];
  logic [WIDTH-1:0]   stack_d [DEPTH];
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;

  logic               is_empty;
  logic               is_full;
  logic [WIDTH-1:0]   masked_status;
  logic [WIDTH-1:0]   top_entry;
  logic               overflow_event;
  logic               underflow_event;

  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == DEPTH_W'(DEPTH));

  // Per-bit merge of the ALU flags into the live word under the write mask.
  assign masked_status = (bus.flags & bus.write_mask) | (status_q & ~bus.write_mask);

  // Select the top valid entry. Entries above depth are don't-care, so the
  // view reads zero when the stack is empty.
  always_comb begin
    top_entry = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_q == DEPTH_W'(i + 1)) begin
        top_entry = stack_q[i];
      end
    end
  end

  // Next-state logic. A successful stack operation takes priority over the
  // masked write. A failed one leaves the stack alone, flags an error, and
  // lets the write through.
  always_comb begin
    status_d        = masked_status;
    depth_d         = depth_q;
    stack_d         = stack_q;
    overflow_event  = 1'b0;
    underflow_event = 1'b0;

    if (bus.push && !bus.pop) begin
      if (is_full) begin
        overflow_event = 1'b1;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (depth_q == DEPTH_W'(i)) begin
            stack_d[i] = status_q;
          end
        end
        depth_d = depth_q + DEPTH_W'(1);
      end
    end else if (bus.pop && !bus.push) begin
      if (is_empty) begin
        underflow_event = 1'b1;
      end else begin
        status_d = top_entry;
        depth_d  = depth_q - DEPTH_W'(1);
      end
    end else if (bus.pop && bus.push) begin
      if (is_empty) begin
        underflow_event = 1'b1;
      end else begin
        status_d = top_entry;
        for (int i = 0; i < DEPTH; i++) begin
          if (depth_q == DEPTH_W'(i + 1)) begin
            stack_d[i] = status_q;
          end
        end
      end
    end

    overflow_d  = (overflow_q  & ~bus.err_clear) | overflow_event;
    underflow_d = (underflow_q & ~bus.err_clear) | underflow_event;
  end

  // Live word, depth and sticky errors, all cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      status_q    <= '0;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      status_q    <= status_d;
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Stack storage. It needs no reset because depth alone decides validity.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign bus.status        = status_q;
  assign bus.saved_top     = top_entry;
  assign bus.depth         = depth_q;
  assign bus.empty         = is_empty;
  assign bus.full          = is_full;
  assign bus.overflow_err  = overflow_q;
  assign bus.underflow_err = underflow_q;
endmodule

// File: tb/tb_flag_stack_register.sv
// Scoreboard bench for flag_stack_register (WIDTH=4, DEPTH=4).
// Each driven cycle runs a queue-based reference model. The expected outputs
// are queued and then compared one cycle later, after the edge.
module tb_flag_stack_register;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;

  flag_stack_register_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  flag_stack_register #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] status;
    logic [3:0] saved_top;
    logic [2:0] depth;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t       scoreboard [$];
  logic [3:0] model_stack [$];
  logic [3:0] model_status;
  logic       model_ovf;
  logic       model_unf;
  int         errors;
  int         checks;

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Upper bound on run time.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.status    = model_status;
    e.depth     = 3'(model_stack.size());
    e.saved_top = (model_stack.size() == 0) ? 4'b0 : model_stack[$];
    e.empty     = (model_stack.size() == 0);
    e.full      = (model_stack.size() == DEPTH);
    e.ovf       = model_ovf;
    e.unf       = model_unf;
    return e;
  endfunction

  task automatic compareNext(input string tag);
    exp_t e;
    if (scoreboard.size() == 0) begin
      checkOutput({tag, "_sb"}, 32'd0, 32'd1);
    end else begin
      e = scoreboard.pop_front();
      checkOutput({tag, "_status"}, 32'(bus.status),        32'(e.status));
      checkOutput({tag, "_top"},    32'(bus.saved_top),     32'(e.saved_top));
      checkOutput({tag, "_depth"},  32'(bus.depth),         32'(e.depth));
      checkOutput({tag, "_empty"},  32'(bus.empty),         32'(e.empty));
      checkOutput({tag, "_full"},   32'(bus.full),          32'(e.full));
      checkOutput({tag, "_ovf"},    32'(bus.overflow_err),  32'(e.ovf));
      checkOutput({tag, "_unf"},    32'(bus.underflow_err), 32'(e.unf));
    end
  endtask

  task automatic applyReset(input string tag);
    @(negedge clk);
    reset          = 1'b1;
    bus.flags      = 4'($urandom);
    bus.write_mask = 4'($urandom);
    bus.push       = 1'($urandom);
    bus.pop        = 1'($urandom);
    bus.err_clear  = 1'b0;
    model_stack.delete();
    model_status = 4'b0;
    model_ovf    = 1'b0;
    model_unf    = 1'b0;
    scoreboard.push_back(snapshot());
    @(posedge clk);
    #1;
    compareNext(tag);
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input string tag, input logic [3:0] f, input logic [3:0] m,
                               input logic ps, input logic pp, input logic clr);
    logic [3:0] merged;
    logic [3:0] tmp;
    logic       ovf_set;
    logic       unf_set;
    @(negedge clk);
    reset          = 1'b0;
    bus.flags      = f;
    bus.write_mask = m;
    bus.push       = ps;
    bus.pop        = pp;
    bus.err_clear  = clr;

    merged  = (f & m) | (model_status & ~m);
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (ps && !pp) begin
      if (model_stack.size() < DEPTH) model_stack.push_back(model_status);
      else ovf_set = 1'b1;
      model_status = merged;
    end else if (pp && !ps) begin
      if (model_stack.size() > 0) model_status = model_stack.pop_back();
      else begin
        unf_set      = 1'b1;
        model_status = merged;
      end
    end else if (pp && ps) begin
      if (model_stack.size() > 0) begin
        tmp = model_stack.pop_back();
        model_stack.push_back(model_status);
        model_status = tmp;
      end else begin
        unf_set      = 1'b1;
        model_status = merged;
      end
    end else begin
      model_status = merged;
    end
    model_ovf = (model_ovf & ~clr) | ovf_set;
    model_unf = (model_unf & ~clr) | unf_set;
    scoreboard.push_back(snapshot());

    @(posedge clk);
    #1;
    compareNext(tag);
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    reset          = 1'b0;
    bus.flags      = '0;
    bus.write_mask = '0;
    bus.push       = 1'b0;
    bus.pop        = 1'b0;
    bus.err_clear  = 1'b0;
    model_status   = '0;
    model_ovf      = 1'b0;
    model_unf      = 1'b0;

    applyReset("reset");

    // Masked writes.
    applyStimulus("wr_full",  4'b1010, 4'b1111, 0, 0, 0);
    checkOutput("wr_full_lit", 32'(bus.status), 32'b1010);
    applyStimulus("wr_part",  4'b0101, 4'b0011, 0, 0, 0);
    checkOutput("wr_part_lit", 32'(bus.status), 32'b1001);
    applyStimulus("wr_hold",  4'b0110, 4'b0000, 0, 0, 0);

    // Nested push and pop.
    applyStimulus("set1",  4'b0001, 4'b1111, 0, 0, 0);
    applyStimulus("push1", 4'b0010, 4'b1111, 1, 0, 0);
    checkOutput("push1_top_lit", 32'(bus.saved_top), 32'b0001);
    applyStimulus("push2", 4'b0000, 4'b0000, 1, 0, 0);
    checkOutput("push2_top_lit", 32'(bus.saved_top), 32'b0010);
    applyStimulus("pop1",  4'b1111, 4'b1111, 0, 1, 0);
    applyStimulus("pop2",  4'b1111, 4'b1111, 0, 1, 0);
    checkOutput("pop2_status_lit", 32'(bus.status), 32'b0001);

    // Fill the stack, then overflow.
    applyStimulus("fill1", 4'b0011, 4'b1111, 1, 0, 0);
    applyStimulus("fill2", 4'b0100, 4'b1111, 1, 0, 0);
    applyStimulus("fill3", 4'b0101, 4'b1111, 1, 0, 0);
    applyStimulus("fill4", 4'b0110, 4'b1111, 1, 0, 0);
    applyStimulus("ovf",   4'b1111, 4'b1111, 1, 0, 0);
    checkOutput("ovf_top_lit", 32'(bus.saved_top), 32'b0101);
    for (int i = 0; i < 4; i++) applyStimulus("drain", 4'b0000, 4'b1111, 0, 1, 0);

    // Underflow, then clear.
    applyStimulus("zero",  4'b0000, 4'b1111, 0, 0, 0);
    applyStimulus("unf",   4'b1100, 4'b1100, 0, 1, 0);
    checkOutput("unf_status_lit", 32'(bus.status), 32'b1100);
    applyStimulus("clr",   4'b0000, 4'b0000, 0, 0, 1);

    // Exchange with one entry, then exchange while empty.
    applyStimulus("xset",  4'b1001, 4'b1111, 0, 0, 0);
    applyStimulus("xpush", 4'b0110, 4'b1111, 1, 0, 0);
    applyStimulus("xchg",  4'b1111, 4'b1111, 1, 1, 0);
    checkOutput("xchg_top_lit", 32'(bus.saved_top), 32'b0110);
    applyStimulus("xpop",  4'b0000, 4'b0000, 0, 1, 0);
    applyStimulus("xempty", 4'b1010, 4'b0110, 1, 1, 0);
    applyStimulus("clr2",  4'b0000, 4'b0000, 0, 0, 1);

    // An error event and err_clear in the same cycle: the set wins.
    applyStimulus("collide", 4'b0000, 4'b0000, 0, 1, 1);
    checkOutput("collide_unf_lit", 32'(bus.underflow_err), 32'd1);

    // A reset in the middle of a nested push chain.
    applyStimulus("chain1", 4'b0001, 4'b1111, 1, 0, 0);
    applyStimulus("chain2", 4'b0010, 4'b1111, 1, 0, 0);
    applyStimulus("chain3", 4'b0011, 4'b1111, 1, 0, 0);
    applyReset("midreset");
    applyStimulus("post_rst_pop", 4'b0000, 4'b0000, 0, 1, 0);

    // Random traffic with an occasional reset.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 40) == 0) applyReset("rnd_rst");
      else applyStimulus("rnd", 4'($urandom), 4'($urandom), 1'($urandom),
                         1'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
